// File: rtl/local_bus_slave_pkg.sv
// Shared constants and the read-pipeline entry type for the local bus register target.
package local_bus_slave_pkg;

    localparam logic [31:0] LB_SLV_ID       = 32'h4C42_0001;
    localparam logic [31:0] LB_SLV_ERR_DATA = 32'hDEAD_BEEF;

    localparam int unsigned LB_RD_LAT_MIN = 1;
    localparam int unsigned LB_RD_LAT_MAX = 4;

    // Entry data is sized for the widest supported bus and truncated at the output.
    localparam int unsigned LB_MAX_DATA_WIDTH = 64;

    typedef struct packed {
        logic                         valid;
        logic [LB_MAX_DATA_WIDTH-1:0] data;
        logic                         err;
    } lb_rd_entry_t;

endpackage

// File: rtl/local_bus_slave_if.sv
// Local bus request/response signal bundle; slv_err exists only with LOCAL_BUS_SLAVE_ERR_EN.
interface local_bus_slave_if #(
    parameter int unsigned ADDR_WIDTH = 16,
    parameter int unsigned DATA_WIDTH = 32
) ();

    logic                  addr_en;
    logic [ADDR_WIDTH-1:0] addr;
    logic                  rw_direction;
    logic [DATA_WIDTH-1:0] wdata;
    logic [DATA_WIDTH-1:0] rdata;
    logic                  rvalid;
`ifdef LOCAL_BUS_SLAVE_ERR_EN
    logic                  slv_err;

    modport master (output addr_en, addr, rw_direction, wdata,
                    input  rdata, rvalid, slv_err);
    modport slave  (input  addr_en, addr, rw_direction, wdata,
                    output rdata, rvalid, slv_err);
`else
    modport master (output addr_en, addr, rw_direction, wdata,
                    input  rdata, rvalid);
    modport slave  (input  addr_en, addr, rw_direction, wdata,
                    output rdata, rvalid);
`endif

endinterface

// File: rtl/local_bus_slave_rd_pipe.sv
// Fixed-depth shift register carrying read responses; flushed synchronously by reset.
module local_bus_slave_rd_pipe
    import local_bus_slave_pkg::*;
#(
    parameter int unsigned READ_LATENCY = 1
) (
    input  logic         clk,
    input  logic         reset,
    input  lb_rd_entry_t req_entry,
    output lb_rd_entry_t rsp_entry
);

    lb_rd_entry_t stage [READ_LATENCY];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < int'(READ_LATENCY); i++) begin
                stage[i] <= '0;
            end
        end else begin
            stage[0] <= req_entry;
            for (int i = 1; i < int'(READ_LATENCY); i++) begin
                stage[i] <= stage[i-1];
            end
        end
    end

    assign rsp_entry = stage[READ_LATENCY-1];

endmodule

// File: rtl/local_bus_slave.sv
// Local bus register-bank target: decode, register file, writes and pipelined reads.
// Optional error reporting (slv_err, error read data) is enabled by LOCAL_BUS_SLAVE_ERR_EN.
module local_bus_slave
    import local_bus_slave_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH   = 16,
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned NUM_REGS     = 8,
    parameter int unsigned READ_LATENCY = 1
) (
    input  logic                           clk,
    input  logic                           reset,
    local_bus_slave_if.slave               bus,
    output logic [NUM_REGS*DATA_WIDTH-1:0] reg_out
);

    localparam int unsigned IDX_W = $clog2(NUM_REGS);

    if (READ_LATENCY < LB_RD_LAT_MIN || READ_LATENCY > LB_RD_LAT_MAX) begin : g_bad_latency
        $error("local_bus_slave: READ_LATENCY out of range");
    end
    if (NUM_REGS < 2 || NUM_REGS > 256) begin : g_bad_num_regs
        $error("local_bus_slave: NUM_REGS out of range");
    end

    logic [DATA_WIDTH-1:0] regs [NUM_REGS];
    logic                  mapped_c;
    logic [IDX_W-1:0]      idx_c;
    logic                  wr_c;
    logic                  rd_c;
    logic [DATA_WIDTH-1:0] rd_word_c;
    lb_rd_entry_t          rd_entry_c;
    lb_rd_entry_t          pipe_rsp;

    // Full-width compare so addresses above the bank never alias onto it.
    always_comb begin
        mapped_c   = (bus.addr < ADDR_WIDTH'(NUM_REGS));
        idx_c      = IDX_W'(bus.addr);
        wr_c       = bus.addr_en & bus.rw_direction & mapped_c & (idx_c != '0);
        rd_c       = bus.addr_en & ~bus.rw_direction;
`ifdef LOCAL_BUS_SLAVE_ERR_EN
        rd_word_c  = DATA_WIDTH'(LB_SLV_ERR_DATA);
`else
        rd_word_c  = '0;
`endif
        if (mapped_c) begin
            rd_word_c = regs[idx_c];
        end
        rd_entry_c       = '0;
        rd_entry_c.valid = rd_c;
        if (rd_c) begin
            rd_entry_c.data = LB_MAX_DATA_WIDTH'(rd_word_c);
        end
`ifdef LOCAL_BUS_SLAVE_ERR_EN
        rd_entry_c.err = rd_c & ~mapped_c;
`endif
    end

    // Register 0 holds the constant ID; only indices 1.. are writable.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < int'(NUM_REGS); i++) begin
                regs[i] <= '0;
            end
            regs[0] <= DATA_WIDTH'(LB_SLV_ID);
        end else if (wr_c) begin
            regs[idx_c] <= bus.wdata;
        end
    end

    always_comb begin
        reg_out = '0;
        for (int i = 0; i < int'(NUM_REGS); i++) begin
            reg_out[i*DATA_WIDTH +: DATA_WIDTH] = regs[i];
        end
    end

    local_bus_slave_rd_pipe #(
        .READ_LATENCY (READ_LATENCY)
    ) u_rd_pipe (
        .clk       (clk),
        .reset     (reset),
        .req_entry (rd_entry_c),
        .rsp_entry (pipe_rsp)
    );

    assign bus.rvalid = pipe_rsp.valid;
    assign bus.rdata  = DATA_WIDTH'(pipe_rsp.data);

`ifdef LOCAL_BUS_SLAVE_ERR_EN
    logic wr_err_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_err_q <= 1'b0;
        end else begin
            wr_err_q <= bus.addr_en & bus.rw_direction & ~mapped_c;
        end
    end

    // Write and read error pulses landing in the same cycle merge into one.
    assign bus.slv_err = wr_err_q | pipe_rsp.err;
`endif

    logic unused_pipe;
    assign unused_pipe = ^pipe_rsp;

endmodule

// File: tb/tb_local_bus_slave.sv
// Directed bench: identical stimulus to three instances with read latency 1, 2 and 3.
module tb_local_bus_slave;
    import local_bus_slave_pkg::*;

    localparam logic [31:0] UNM_RD =
`ifdef LOCAL_BUS_SLAVE_ERR_EN
        32'hDEAD_BEEF;
`else
        32'h0000_0000;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        addr_en = 1'b0;
    logic [15:0] addr = '0;
    logic        rw_direction = 1'b0;
    logic [31:0] wdata = '0;
    logic [255:0] reg_out1, reg_out2, reg_out3;

    int edge_cnt = 0;
    int n_checks = 0;
    int n_fail = 0;
    bit mon_en = 1'b0;

    bit        exp_v [3][1024];
    bit [31:0] exp_d [3][1024];
    bit        exp_e [3][1024];
    bit [31:0] shadow [8];

    always #5 clk = ~clk;
    always @(posedge clk) edge_cnt = edge_cnt + 1;

    local_bus_slave_if #(.ADDR_WIDTH(16), .DATA_WIDTH(32)) bus1 ();
    local_bus_slave_if #(.ADDR_WIDTH(16), .DATA_WIDTH(32)) bus2 ();
    local_bus_slave_if #(.ADDR_WIDTH(16), .DATA_WIDTH(32)) bus3 ();

    assign bus1.addr_en = addr_en; assign bus1.addr = addr;
    assign bus1.rw_direction = rw_direction; assign bus1.wdata = wdata;
    assign bus2.addr_en = addr_en; assign bus2.addr = addr;
    assign bus2.rw_direction = rw_direction; assign bus2.wdata = wdata;
    assign bus3.addr_en = addr_en; assign bus3.addr = addr;
    assign bus3.rw_direction = rw_direction; assign bus3.wdata = wdata;

    local_bus_slave #(.ADDR_WIDTH(16), .DATA_WIDTH(32), .NUM_REGS(8), .READ_LATENCY(1))
        u_l1 (.clk(clk), .reset(reset), .bus(bus1), .reg_out(reg_out1));
    local_bus_slave #(.ADDR_WIDTH(16), .DATA_WIDTH(32), .NUM_REGS(8), .READ_LATENCY(2))
        u_l2 (.clk(clk), .reset(reset), .bus(bus2), .reg_out(reg_out2));
    local_bus_slave #(.ADDR_WIDTH(16), .DATA_WIDTH(32), .NUM_REGS(8), .READ_LATENCY(3))
        u_l3 (.clk(clk), .reset(reset), .bus(bus3), .reg_out(reg_out3));

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Instance i has read latency i+1.
    task automatic expect_rd(input int n, input bit [31:0] d, input bit e);
        for (int i = 0; i < 3; i++) begin
            exp_v[i][n+i] = 1'b1;
            exp_d[i][n+i] = d;
            exp_e[i][n+i] = exp_e[i][n+i] | e;
        end
    endtask

    task automatic flush_from(input int e_edge);
        for (int i = 0; i < 3; i++) begin
            for (int t = e_edge; t < 1024; t++) begin
                exp_v[i][t] = 1'b0;
                exp_d[i][t] = '0;
                exp_e[i][t] = 1'b0;
            end
        end
    endtask

    task automatic issue(input bit wr, input logic [15:0] a, input logic [31:0] d,
                         input logic [31:0] exp);
        int n;
        n = edge_cnt + 1;
        addr_en = 1'b1; rw_direction = wr; addr = a; wdata = d;
        if (!wr) begin
            expect_rd(n, exp, a >= 16'd8);
        end else if (a >= 16'd8) begin
            for (int i = 0; i < 3; i++) exp_e[i][n] = 1'b1;
        end else if (a != 16'd0) begin
            shadow[a[2:0]] = d;
        end
        @(posedge clk); #1;
    endtask

    task automatic idle(input int cycles);
        addr_en = 1'b0; rw_direction = 1'b0; addr = '0; wdata = '0;
        repeat (cycles) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic chk_regs(input string tag);
        logic [255:0] exp;
        for (int i = 0; i < 8; i++) exp[i*32 +: 32] = shadow[i];
        check({tag, "_L1"}, reg_out1, exp);
        check({tag, "_L2"}, reg_out2, exp);
        check({tag, "_L3"}, reg_out3, exp);
    endtask

    task automatic mon(input int i, input logic v, input logic [31:0] d);
        int c;
        c = edge_cnt;
        check($sformatf("rvalid_L%0d_e%0d", i + 1, c), v, exp_v[i][c]);
        check($sformatf("rdata_L%0d_e%0d", i + 1, c), d, exp_d[i][c]);
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            mon(0, bus1.rvalid, bus1.rdata);
            mon(1, bus2.rvalid, bus2.rdata);
            mon(2, bus3.rvalid, bus3.rdata);
`ifdef LOCAL_BUS_SLAVE_ERR_EN
            check($sformatf("slv_err_L1_e%0d", edge_cnt), bus1.slv_err, exp_e[0][edge_cnt]);
            check($sformatf("slv_err_L2_e%0d", edge_cnt), bus2.slv_err, exp_e[1][edge_cnt]);
            check($sformatf("slv_err_L3_e%0d", edge_cnt), bus3.slv_err, exp_e[2][edge_cnt]);
`endif
        end
    end

    initial begin
        for (int i = 0; i < 8; i++) shadow[i] = '0;
        shadow[0] = 32'h4C42_0001;

        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        mon_en = 1'b1;
        chk_regs("reset_regs");

        // ID then zeros from a fresh bank
        for (int i = 0; i < 8; i++) begin
            issue(1'b0, 16'(i), '0, (i == 0) ? 32'h4C42_0001 : 32'h0);
        end
        idle(1);

        issue(1'b1, 16'd3, 32'hA5A5_0003, '0);
        check("reg3_after_write", reg_out1[127:96], 32'hA5A5_0003);
        chk_regs("write3");
        issue(1'b0, 16'd3, '0, 32'hA5A5_0003);
        idle(1);

        issue(1'b1, 16'd1, 32'h11, '0);
        issue(1'b1, 16'd2, 32'h22, '0);
        issue(1'b1, 16'd3, 32'h33, '0);
        issue(1'b1, 16'd4, 32'h44, '0);
        issue(1'b0, 16'd1, '0, 32'h11);
        issue(1'b0, 16'd2, '0, 32'h22);
        issue(1'b0, 16'd3, '0, 32'h33);
        issue(1'b0, 16'd4, '0, 32'h44);
        idle(4);

        // write right behind an in-flight read must not disturb it
        issue(1'b1, 16'd2, 32'h5, '0);
        idle(2);
        issue(1'b0, 16'd2, '0, 32'h5);
        issue(1'b1, 16'd2, 32'h9, '0);
        issue(1'b0, 16'd2, '0, 32'h9);
        idle(4);
        issue(1'b0, 16'd2, '0, 32'h9);
        idle(4);

        issue(1'b1, 16'd7, 32'h7777, '0);
        issue(1'b0, 16'd7, '0, 32'h7777);
        issue(1'b0, 16'd8, '0, UNM_RD);
        idle(4);
        chk_regs("before_reset");

        // reset one cycle after a read; a write presented during reset is ignored
        issue(1'b1, 16'd1, 32'h77, '0);
        issue(1'b0, 16'd1, '0, 32'h77);
        flush_from(edge_cnt + 1);
        reset = 1'b1; addr_en = 1'b1; rw_direction = 1'b1; addr = 16'd2; wdata = 32'hBAD;
        @(posedge clk); #1;
        reset = 1'b0; addr_en = 1'b0; rw_direction = 1'b0;
        for (int i = 1; i < 8; i++) shadow[i] = '0;
        chk_regs("after_reset");
        issue(1'b0, 16'd1, '0, 32'h0);
        issue(1'b0, 16'd2, '0, 32'h0);
        idle(4);

        issue(1'b0, 16'h20, '0, UNM_RD);
        idle(4);
        issue(1'b1, 16'h20, 32'h1234, '0);
        chk_regs("unmapped_write");
        idle(2);
        issue(1'b1, 16'd0, 32'hFFFF, '0);
        chk_regs("write_reg0");
        idle(2);
        issue(1'b0, 16'd0, '0, 32'h4C42_0001);
        idle(2);
        issue(1'b0, 16'h20, '0, UNM_RD);
        issue(1'b1, 16'h20, 32'h5678, '0);
        idle(5);

        mon_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/local_bus_slave.md
# local_bus_slave

Register-bank responder for the local bus: the target end of the master interface that drives `addr_en`/`addr`/`rw_direction`/`wdata`. It decodes single-cycle requests, performs writes into a small register file, and returns read data with a fixed, parameterised `rvalid` latency. It sits behind the local bus in the DUT wrapper and gives the register model and UVM bench a synthesizable target.

## Interface
- `ADDR_WIDTH`, 16: local bus address width.
- `DATA_WIDTH`, 32: local bus data width.
- `NUM_REGS`, 8: number of word registers; valid range 2..256.
- `READ_LATENCY`, 1: cycles from request sample to `rvalid`; valid range 1..4.
- `clk` input 1: single clock; all logic samples on its rising edge.
- `reset` input 1: synchronous, active-high reset.
- `addr_en` input 1: request strobe, one cycle per request.
- `addr` input ADDR_WIDTH: word index of the target register.
- `rw_direction` input 1: 1 selects a write, 0 selects a read.
- `wdata` input DATA_WIDTH: write data.
- `rdata` output DATA_WIDTH: read data; valid only while `rvalid` is high.
- `rvalid` output 1: one-cycle read-response strobe.
- `reg_out` output NUM_REGS*DATA_WIDTH: flattened current register contents; register 0 occupies the LSBs.
- `slv_err` output 1: only present with `LOCAL_BUS_SLAVE_ERR_EN`; see Configuration.

## Operation
- A request is taken on any rising edge where `addr_en`=1. There is no backpressure, and every request is accepted.
- Address `addr` is mapped when `addr` < NUM_REGS; all higher bits are decoded, so there is no aliasing.
- Register 0 is read-only and returns `LB_SLV_ID`. Writes to it are ignored and do not raise an error.
- Registers 1..NUM_REGS-1 are read/write and reset to 0.
- Write: the register updates on the sampling edge. `reg_out` shows the new value from the next cycle.
- Read: data is captured from the register file as it was before any write on the same edge, then carried through the read pipeline.
- A read issued the cycle after a write to the same address returns the new value.
- A write landing while an earlier read is still in the pipeline does not change that read's returned data.
- Unmapped read returns 0 and still produces `rvalid`. Unmapped write is dropped.
- Back-to-back reads on consecutive cycles are fully pipelined, giving one `rvalid` per read in issue order.
- Reads and writes may be interleaved freely. Only reads generate `rvalid`.

## Timing
- Read sampled at edge N produces `rvalid`=1 and `rdata` during the cycle after edge N+READ_LATENCY-1. With READ_LATENCY=1, the response is registered and appears the cycle after the request.
- `rdata` is 0 whenever `rvalid`=0.
- Reset values: `rvalid`=0, `rdata`=0, `slv_err`=0, `reg_out`=0 except for the `LB_SLV_ID` field.
- Reset asserted mid-operation flushes the read pipeline and clears the registers. No `rvalid` is produced for reads issued before reset.
- Requests on an edge where `reset`=1 are ignored.

## Configuration
- Macro: `LOCAL_BUS_SLAVE_ERR_EN`.
- Defined:
  - `slv_err` port exists.
  - An unmapped read returns `LB_SLV_ERR_DATA` (0xDEAD_BEEF, truncated to DATA_WIDTH). `slv_err` pulses together with that read's `rvalid`.
  - An unmapped write pulses `slv_err` for one cycle, the cycle after the request.
  - If an unmapped-write pulse and an unmapped-read pulse fall in the same cycle, they merge into one pulse.
- Undefined:
  - No `slv_err` port.
  - Unmapped reads return 0 and unmapped writes are silently dropped.

## Structure
- Package `local_bus_slave_pkg` holds:
  - `LB_SLV_ID` (default 32'h4C42_0001).
  - `LB_SLV_ERR_DATA`.
  - The read-latency bounds.
  - A typedef for the pipeline entry struct: valid, data, err.
- Sub-module `local_bus_slave_rd_pipe`: a READ_LATENCY-deep shift register of pipeline entries, with synchronous flush on `reset`.
- The top level holds the address decode, the register file and the write logic.

## Test plan
- Reset, then read addresses 0..7 (NUM_REGS=8, latency 1):
  - address 0 returns 0x4C42_0001;
  - addresses 1..7 return 0;
  - each `rvalid` arrives exactly 1 cycle after its request.
- Write 0xA5A5_0003 to address 3, then read address 3 the next cycle:
  - the read returns 0xA5A5_0003;
  - `reg_out[127:96]` shows the new value.
- READ_LATENCY=3, with four back-to-back reads of addresses 1..4 after writing 0x11..0x44:
  - `rvalid` is high for 4 consecutive cycles, starting 3 cycles after the first request;
  - data arrives in order.
- Read address 2 (holding 0x5), then write 0x9 to address 2 on the next cycle, with latency 2:
  - the read returns 0x5;
  - a later read returns 0x9.
- Assert `reset` one cycle after a read request with latency 3:
  - no `rvalid` appears;
  - address 1 reads 0 afterwards.
- With `LOCAL_BUS_SLAVE_ERR_EN`:
  - a read of address 0x20 returns 0xDEAD_BEEF with `slv_err`=1 alongside `rvalid`;
  - a write to 0x20 pulses `slv_err` once and leaves `reg_out` unchanged;
  - a write to address 0 leaves `slv_err` at 0.
